// File: rtl/demux_pkg.sv
// demux_pkg: shared sizes and channel index type for the demux router
package demux_pkg;
  localparam int NUM_OUT = 4;
  localparam int ADDR_W = 2;
  localparam int CNT_W = 8;
  typedef logic [ADDR_W-1:0] sel_t;
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register with valid/ready handshake
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data_out
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  // a load always wins over a same-cycle drain, so the slot stays full
  always_comb begin
    valid_d = load | (valid_q & ~ready);
    data_d  = load ? data_in : data_q;
  end
  // slot state; data only moves on a load so it holds while empty
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid    = valid_q;
  assign data_out = data_q;
endmodule

// File: rtl/demux_router.sv
// demux_router: 1-to-4 address-routed demux with per-channel holding slots
// Optional per-channel transfer counters enabled by DEMUX_COUNT_EN.
module demux_router
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             address0,
  input  logic             address1,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             out_valid0,
  output logic             out_valid1,
  output logic             out_valid2,
  output logic             out_valid3,
`ifdef DEMUX_COUNT_EN
  input  logic             count_clr,
  output logic [CNT_W-1:0] count0,
  output logic [CNT_W-1:0] count1,
  output logic [CNT_W-1:0] count2,
  output logic [CNT_W-1:0] count3,
`endif
  input  logic             out_ready0,
  input  logic             out_ready1,
  input  logic             out_ready2,
  input  logic             out_ready3
);
  sel_t               sel;
  logic               accept;
  logic [NUM_OUT-1:0] vld, rdy, load;
  logic [WIDTH-1:0]   dout [NUM_OUT];

  assign sel      = {address1, address0};
  assign rdy      = {out_ready3, out_ready2, out_ready1, out_ready0};
  assign in_ready = ~vld[sel] | rdy[sel];
  assign accept   = in_valid & in_ready;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
    assign load[g] = accept && (sel == sel_t'(g));
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (load[g]),
      .data_in  (in_data),
      .ready    (rdy[g]),
      .valid    (vld[g]),
      .data_out (dout[g])
    );
  end

  assign {out_valid3, out_valid2, out_valid1, out_valid0} = vld;
  assign out0 = dout[0];
  assign out1 = dout[1];
  assign out2 = dout[2];
  assign out3 = dout[3];

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_OUT];
  logic [CNT_W-1:0] cnt_d [NUM_OUT];
  // clear beats increment; counters wrap naturally at 2**CNT_W
  always_comb begin
    for (int i = 0; i < NUM_OUT; i++) cnt_d[i] = count_clr ? '0 : cnt_q[i] + CNT_W'(load[i]);
  end
  // per-channel accepted-transfer counters
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_OUT; i++) cnt_q[i] <= !reset_n ? '0 : cnt_d[i];
  end
  assign count0 = cnt_q[0];
  assign count1 = cnt_q[1];
  assign count2 = cnt_q[2];
  assign count3 = cnt_q[3];
`endif
endmodule

// File: tb/tb_demux_router.sv
// tb_demux_router: scoreboard bench for the 1-to-4 demux router
module tb_demux_router;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       address0 = 1'b0;
  logic       address1 = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [3:0] ordy = 4'h0;
  wire        in_ready;
  wire  [7:0] o0, o1, o2, o3;
  wire        v0, v1, v2, v3;
  logic [7:0] o [4];
  logic [3:0] ov;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] q [4][$];
`ifdef DEMUX_COUNT_EN
  logic       count_clr = 1'b0;
  wire  [7:0] count0, count1, count2, count3;
`endif

  assign o[0] = o0;
  assign o[1] = o1;
  assign o[2] = o2;
  assign o[3] = o3;
  assign ov = {v3, v2, v1, v0};

  demux_router #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .address0   (address0),
    .address1   (address1),
    .out0       (o0),
    .out1       (o1),
    .out2       (o2),
    .out3       (o3),
    .out_valid0 (v0),
    .out_valid1 (v1),
    .out_valid2 (v2),
    .out_valid3 (v3),
`ifdef DEMUX_COUNT_EN
    .count_clr  (count_clr),
    .count0     (count0),
    .count1     (count1),
    .count2     (count2),
    .count3     (count3),
`endif
    .out_ready0 (ordy[0]),
    .out_ready1 (ordy[1]),
    .out_ready2 (ordy[2]),
    .out_ready3 (ordy[3])
  );

  always #5 clk = ~clk;

  // Scoreboard: inputs are driven just after posedge, so values seen at
  // negedge are the ones the next posedge acts on.
  always @(negedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < 4; c++) q[c].delete();
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (ov[c]) begin
          if (q[c].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_ch%0d got valid=1 data=%h want valid=0", c, o[c]);
          end else if (ordy[c]) begin
            checks++;
            if (o[c] !== q[c][0]) begin
              errors++;
              $display("FAIL drain_ch%0d got %h want %h", c, o[c], q[c][0]);
            end
            void'(q[c].pop_front());
          end
        end
      end
      if (in_valid && in_ready) q[{address1, address0}].push_back(in_data);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hFF;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (ov !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b want 0000", ov); end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (o[c] !== 8'h00) begin errors++; $display("FAIL reset_out%0d got %h want 00", c, o[c]); end
    end
    reset_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_routing;
    ordy = 4'hF;
    tick();
    for (int s = 0; s < 4; s++) begin
      {address1, address0} = s[1:0];
      in_data = 8'(8'hA0 + s);
      in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL route_ready_%0d got %b want 1", s, in_ready); end
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (ov !== (4'b0001 << s)) begin errors++; $display("FAIL route_valid_%0d got %b want %b", s, ov, 4'b0001 << s); end
      checks++;
      if (o[s] !== 8'(8'hA0 + s)) begin errors++; $display("FAIL route_data_%0d got %h want %h", s, o[s], 8'(8'hA0 + s)); end
      tick();
    end
  endtask

  task automatic test_backpressure;
    ordy = 4'b1011;
    {address1, address0} = 2'd2;
    in_data = 8'h55;
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready got %b want 1", in_ready); end
    tick();
    in_data = 8'h66;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready got %b want 0", in_ready); end
    checks++;
    if (ov[2] !== 1'b1 || o[2] !== 8'h55) begin errors++; $display("FAIL bp_hold got v=%b d=%h want v=1 d=55", ov[2], o[2]); end
    tick();
    {address1, address0} = 2'd1;
    in_data = 8'h77;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_other_ready got %b want 1", in_ready); end
    tick();
    {address1, address0} = 2'd2;
    in_data = 8'h66;
    ordy = 4'hF;
    @(negedge clk);
    checks++;
    if (ov[1] !== 1'b1 || o[1] !== 8'h77) begin errors++; $display("FAIL bp_ch1 got v=%b d=%h want v=1 d=77", ov[1], o[1]); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ov[2] !== 1'b1 || o[2] !== 8'h66) begin errors++; $display("FAIL bp_land got v=%b d=%h want v=1 d=66", ov[2], o[2]); end
    tick();
  endtask

  task automatic test_back_to_back;
    ordy = 4'hF;
    {address1, address0} = 2'd3;
    for (int i = 0; i < 16; i++) begin
      in_data = 8'(i * 7 + 3);
      in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d got %b want 1", i, in_ready); end
      if (i > 0) begin
        checks++;
        if (ov[3] !== 1'b1 || o[3] !== 8'((i - 1) * 7 + 3))
          begin errors++; $display("FAIL b2b_data_%0d got v=%b d=%h want v=1 d=%h", i, ov[3], o[3], 8'((i - 1) * 7 + 3)); end
      end
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ov[3] !== 1'b1 || o[3] !== 8'd108) begin errors++; $display("FAIL b2b_last got v=%b d=%h want v=1 d=6c", ov[3], o[3]); end
    tick();
  endtask

  task automatic test_mid_reset;
    ordy = 4'h0;
    {address1, address0} = 2'd0;
    in_data = 8'h11;
    in_valid = 1'b1;
    tick();
    {address1, address0} = 2'd3;
    in_data = 8'h33;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ov !== 4'b1001) begin errors++; $display("FAIL mid_full got %b want 1001", ov); end
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ov !== 4'b0000) begin errors++; $display("FAIL mid_reset_valid got %b want 0000", ov); end
    checks++;
    if (o[0] !== 8'h00 || o[3] !== 8'h00) begin errors++; $display("FAIL mid_reset_data got %h/%h want 00/00", o[0], o[3]); end
    ordy = 4'hF;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (ov !== 4'b0000) begin errors++; $display("FAIL mid_no_replay got %b want 0000", ov); end
    tick();
  endtask

`ifdef DEMUX_COUNT_EN
  task automatic test_count;
    ordy = 4'hF;
    @(negedge clk);
    checks++;
    if (count0 !== 8'd0) begin errors++; $display("FAIL cnt_start got %0d want 0", count0); end
    tick();
    {address1, address0} = 2'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 257; i++) begin
      in_data = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (count0 !== 8'd1) begin errors++; $display("FAIL cnt_wrap got %0d want 1", count0); end
    tick();
    {address1, address0} = 2'd1;
    in_data = 8'h5A;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (count1 !== 8'd1) begin errors++; $display("FAIL cnt_ch1 got %0d want 1", count1); end
    tick();
    {address1, address0} = 2'd0;
    in_data = 8'hC3;
    in_valid = 1'b1;
    count_clr = 1'b1;
    tick();
    in_valid = 1'b0;
    count_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (count0 !== 8'd0 || count1 !== 8'd0) begin errors++; $display("FAIL cnt_clr got %0d/%0d want 0/0", count0, count1); end
    tick();
  endtask
`endif

  task automatic test_drained;
    in_valid = 1'b0;
    repeat (3) tick();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (q[c].size() != 0) begin errors++; $display("FAIL leftover_ch%0d got %0d pending want 0", c, q[c].size()); end
    end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
`ifdef DEMUX_COUNT_EN
    test_count();
`endif
    test_drained();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
